// File: rtl/pixel_pkg.sv
// Shared constants and FSM encoding for the camera capture path.
package pixel_pkg;
  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;

  localparam logic SRAM_WRITE = 1'b1;
  localparam logic SRAM_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;
endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous word FIFO; pushes when full and pops when empty are ignored.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/pixel_input.sv
// Captures one camera frame, packs byte pairs into words and writes them to SRAM
// through the mux; publishes the first unwritten address as stop_addr.
module pixel_input
  import pixel_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 16'h0000,
  parameter logic [ADDR_W-1:0] MAX_ADDR     = 16'hFFFF,
  parameter int                FIFO_DEPTH   = 4,
  parameter logic              VSYNC_ACTIVE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_req,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] stop_addr,
  output logic              overrun,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              sram_start,
  output logic              sram_rw,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_data,
  input  logic              sram_ready,
  output state_e            state
);
  localparam logic [10:0] SYNC_RST = {1'b0, ~VSYNC_ACTIVE, 9'd0};

  logic [10:0] sync1, sync2;
  logic        pclk_q, vsync_q, href_q;
  logic        pclk_s, vsync_s, href_s;
  logic [7:0]  data_s;
  logic        pclk_rise, href_fall, vsync_end, vsync_start;

  logic              half_valid;
  logic [7:0]        half_byte;
  logic              push_req;
  logic [WORD_W-1:0] push_word;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [WORD_W-1:0] fifo_head;
  logic              writing, issue, discard, drop;

  logic [ADDR_W-1:0] wr_addr;
  logic              addr_limit;
  logic              wr_pending;
  logic              seen_low;

  assign {pclk_s, vsync_s, href_s, data_s} = sync2;
  assign pclk_rise   = pclk_s && !pclk_q;
  assign href_fall   = href_q && !href_s;
  assign vsync_end   = (vsync_q == VSYNC_ACTIVE) && (vsync_s != VSYNC_ACTIVE);
  assign vsync_start = (vsync_q != VSYNC_ACTIVE) && (vsync_s == VSYNC_ACTIVE);

  // All camera signals share one synchroniser chain so they keep equal delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= SYNC_RST;
      sync2   <= SYNC_RST;
      pclk_q  <= 1'b0;
      vsync_q <= ~VSYNC_ACTIVE;
      href_q  <= 1'b0;
    end else begin
      sync1   <= {cam_pclk, cam_vsync, cam_href, cam_data};
      sync2   <= sync1;
      pclk_q  <= pclk_s;
      vsync_q <= vsync_s;
      href_q  <= href_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_valid <= 1'b0;
      half_byte  <= 8'h00;
      push_req   <= 1'b0;
      push_word  <= '0;
    end else begin
      push_req <= 1'b0;
      case (state)
        ST_CAPTURE: begin
          if (pclk_rise && href_s) begin
            if (half_valid) begin
              push_req   <= 1'b1;
              push_word  <= {half_byte, data_s};
              half_valid <= 1'b0;
            end else begin
              half_byte  <= data_s;
              half_valid <= 1'b1;
            end
          end else if (href_fall && half_valid) begin
            push_req   <= 1'b1;
            push_word  <= {half_byte, 8'h00};
            half_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (half_valid) begin
            push_req   <= 1'b1;
            push_word  <= {half_byte, 8'h00};
            half_valid <= 1'b0;
          end
        end
        default: half_valid <= 1'b0;
      endcase
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_word),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // SRAM handshake: sram_start is a one-cycle strobe issued only while sram_ready=1;
  // the request is outstanding until sram_ready is seen low and then high again.
  assign writing  = ((state == ST_CAPTURE) || (state == ST_FLUSH)) && !fifo_empty &&
                    !wr_pending && (addr_limit || sram_ready);
  assign issue    = writing && !addr_limit;
  assign discard  = writing && addr_limit;
  assign fifo_pop = writing;
  assign drop     = push_req && fifo_full;
  assign sram_rw  = SRAM_WRITE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      stop_addr  <= BASE_ADDR;
      overrun    <= 1'b0;
      sram_start <= 1'b0;
      sram_addr  <= BASE_ADDR;
      sram_data  <= '0;
      wr_addr    <= BASE_ADDR;
      addr_limit <= 1'b0;
      wr_pending <= 1'b0;
      seen_low   <= 1'b0;
    end else begin
      sram_start <= 1'b0;
      frame_done <= 1'b0;
      if (drop || discard) overrun <= 1'b1;

      if (issue) begin
        sram_start <= 1'b1;
        sram_addr  <= wr_addr;
        sram_data  <= fifo_head;
        wr_pending <= 1'b1;
        seen_low   <= 1'b0;
      end else if (wr_pending) begin
        if (!sram_ready) begin
          seen_low <= 1'b1;
        end else if (seen_low) begin
          wr_pending <= 1'b0;
          seen_low   <= 1'b0;
          // A full 16-bit address space saturates instead of wrapping.
          if (wr_addr == MAX_ADDR) begin
            addr_limit <= 1'b1;
            if (MAX_ADDR != 16'hFFFF) wr_addr <= MAX_ADDR + 16'd1;
          end else begin
            wr_addr <= wr_addr + 16'd1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (capture_req) begin
            state      <= ST_ARM;
            busy       <= 1'b1;
            overrun    <= 1'b0;
            wr_addr    <= BASE_ADDR;
            addr_limit <= 1'b0;
          end
        end
        ST_ARM:     if (vsync_end) state <= ST_CAPTURE;
        ST_CAPTURE: if (vsync_start) state <= ST_FLUSH;
        ST_FLUSH: begin
          if (fifo_empty && !wr_pending && !push_req && !half_valid) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
            stop_addr  <= wr_addr;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
